// File: rtl/motor_pkg.sv
// -----------------------------------------------------------------------------
// motor_pkg
// Shared types and helpers for the N-channel H-bridge motor driver.
//   mode_t     : per-channel bridge mode (BRAKE, FWD, REV, DEAD)
//   PINS_*     : {fwd, rev} pin encodings for the static modes
//   decode_t   : decoded command (target mode + PWM magnitude)
//   sat_abs()  : decodes a sign-extended speed command into mode + magnitude,
//                saturating the most-negative code to the largest duty
// -----------------------------------------------------------------------------
package motor_pkg;

    typedef enum logic [1:0] {
        BRAKE = 2'd0,
        FWD   = 2'd1,
        REV   = 2'd2,
        DEAD  = 2'd3
    } mode_t;

    // Widest PWM magnitude the decode helper supports (W must not exceed this).
    localparam int MAX_W = 16;

    // Pin encodings, ordered {fwd, rev}.
    localparam logic [1:0] PINS_BRAKE = 2'b11;
    localparam logic [1:0] PINS_COAST = 2'b00;

    typedef struct packed {
        mode_t            mode;
        logic [MAX_W-1:0] mag;
    } decode_t;

    // cmd is the channel command sign-extended to MAX_W+1 bits; w is the real
    // magnitude width. -2^w has no positive twin in w bits, so it clamps to
    // 2^w-1 instead of wrapping to zero.
    function automatic decode_t sat_abs(input logic [MAX_W:0] cmd, input int w);
        decode_t        d;
        logic [MAX_W:0] one;
        logic [MAX_W:0] full;
        logic [MAX_W:0] neg;
        one    = (MAX_W+1)'(1);
        full   = one << w;
        neg    = ~cmd + one;
        d.mode = BRAKE;
        d.mag  = '0;
        if (cmd[MAX_W]) begin
            d.mode = REV;
            d.mag  = (neg == full) ? MAX_W'(full - one) : neg[MAX_W-1:0];
        end else if (cmd != '0) begin
            d.mode = FWD;
            d.mag  = cmd[MAX_W-1:0];
        end
        return d;
    endfunction

endpackage

// File: rtl/motor_chan.sv
// -----------------------------------------------------------------------------
// motor_chan
// One bridge channel: command decode, mode FSM with dead-time on reversal,
// duty/pending registers, PWM compare and registered pin outputs.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   cmd        : W+1-bit two's-complement speed command
//   cnt        : shared W-bit PWM timebase
//   boundary   : 1 in the last cycle of a PWM period (cnt == 2^W-1)
//   fwd, rev   : registered bridge inputs
//   dead       : registered, 1 while the channel coasts in DEAD
// -----------------------------------------------------------------------------
module motor_chan
    import motor_pkg::*;
#(
    parameter int W        = 10,
    parameter int DEAD_CYC = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W:0]   cmd,
    input  logic [W-1:0] cnt,
    input  logic         boundary,
    output logic         fwd,
    output logic         rev,
    output logic         dead
);

    localparam int            DW        = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [DW-1:0] DEAD_INIT = DW'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);

    mode_t         state, state_n;
    mode_t         pending, pending_n;
    logic [W-1:0]  duty, duty_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [1:0]    pins_n;
    logic          dead_n;
    logic          p;

    logic signed [W:0] cmd_s;
    decode_t           dec;
    logic [W-1:0]      mag;
    logic              unused_mag;

    assign cmd_s      = cmd;
    assign dec        = sat_abs((MAX_W+1)'(cmd_s), W);
    assign mag        = dec.mag[W-1:0];
    assign unused_mag = &{1'b0, dec.mag};
    assign p          = (cnt < duty);

    // NOTE: every variable gets its default before the case so no path leaves
    // one unassigned; a missing default here would infer a latch.
    always_comb begin
        state_n   = state;
        pending_n = pending;
        duty_n    = duty;
        dcnt_n    = dcnt;
        case (state)
            BRAKE: begin
                if (boundary && dec.mode != BRAKE) begin
                    state_n = dec.mode;
                    duty_n  = mag;
                end
            end
            FWD, REV: begin
                if (boundary) begin
                    if (dec.mode == BRAKE) begin
                        state_n = BRAKE;
                    end else if (dec.mode == state) begin
                        duty_n = mag;
                    end else if (DEAD_CYC > 0) begin
                        // Reversal: coast first, remember where we are heading.
                        state_n   = DEAD;
                        dcnt_n    = DEAD_INIT;
                        pending_n = dec.mode;
                        duty_n    = mag;
                    end else begin
                        state_n = dec.mode;
                        duty_n  = mag;
                    end
                end
            end
            DEAD: begin
                // A boundary only retargets the exit; the coast interval runs on.
                if (boundary) begin
                    pending_n = dec.mode;
                    duty_n    = mag;
                end
                if (dcnt == '0) begin
                    state_n = boundary ? dec.mode : pending;
                end else begin
                    dcnt_n = dcnt - DW'(1);
                end
            end
            default: state_n = BRAKE;
        endcase
    end

    always_comb begin
        pins_n = PINS_COAST;
        dead_n = 1'b0;
        case (state)
            BRAKE:   pins_n = PINS_BRAKE;
            FWD:     pins_n = {p, 1'b0};
            REV:     pins_n = {1'b0, p};
            DEAD:    dead_n = 1'b1;
            default: pins_n = PINS_BRAKE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= BRAKE;
            pending <= BRAKE;
            duty    <= '0;
            dcnt    <= '0;
            fwd     <= PINS_BRAKE[1];
            rev     <= PINS_BRAKE[0];
            dead    <= 1'b0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            duty    <= duty_n;
            dcnt    <= dcnt_n;
            fwd     <= pins_n[1];
            rev     <= pins_n[0];
            dead    <= dead_n;
        end
    end

endmodule

// File: rtl/motor_drive_n.sv
// -----------------------------------------------------------------------------
// motor_drive_n
// N-channel H-bridge PWM driver with a shared timebase. Each channel latches
// its command only at the period boundary and inserts a coast interval on
// direction reversal.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   cmd        : N_CH x (W+1)-bit signed speeds, channel i at [i*(W+1) +: W+1]
//   fwd, rev   : registered bridge inputs, one bit per channel
//   dead       : registered, 1 while a channel is coasting for dead-time
//   pwm_sync   : registered one-clock pulse in the cycle cnt == 0
// -----------------------------------------------------------------------------
module motor_drive_n
    import motor_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int W        = 10,
    parameter int DEAD_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*(W+1)-1:0]  cmd,
    output logic [N_CH-1:0]        fwd,
    output logic [N_CH-1:0]        rev,
    output logic [N_CH-1:0]        dead,
    output logic                   pwm_sync
);

    logic [W-1:0] cnt;
    logic         boundary;

    assign boundary = &cnt;

    // pwm_sync is registered from the boundary so it lands in the cnt == 0 cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            pwm_sync <= 1'b0;
        end else begin
            cnt      <= cnt + W'(1);
            pwm_sync <= boundary;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        motor_chan #(
            .W        (W),
            .DEAD_CYC (DEAD_CYC)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .cmd      (cmd[i*(W+1) +: W+1]),
            .cnt      (cnt),
            .boundary (boundary),
            .fwd      (fwd[i]),
            .rev      (rev[i]),
            .dead     (dead[i])
        );
    end

endmodule

// File: tb/tb_motor_drive_n.sv
// -----------------------------------------------------------------------------
// tb_motor_drive_n
// Directed bench for motor_drive_n (N_CH=2, W=10). The main instance uses
// DEAD_CYC=8; a second instance with DEAD_CYC=0 shares clock, reset and
// commands to show the direct reversal. Outputs are sampled 1 time unit after
// the rising edge; a cycle whose pwm_sync is 1 has cnt == 0.
// -----------------------------------------------------------------------------
module tb_motor_drive_n;

    localparam int N_CH = 2;
    localparam int W    = 10;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N_CH*(W+1)-1:0] cmd   = '0;
    logic [N_CH-1:0]       fwd, rev, dead;
    logic [N_CH-1:0]       fwd_z, rev_z, dead_z;
    logic                  pwm_sync, pwm_sync_z;

    int total = 0;
    int bad   = 0;

    int cf0, cr0, cf1, cr1, cd, cs;

    always #5 clk = ~clk;

    motor_drive_n #(.N_CH(N_CH), .W(W), .DEAD_CYC(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmd),
        .fwd      (fwd),
        .rev      (rev),
        .dead     (dead),
        .pwm_sync (pwm_sync)
    );

    motor_drive_n #(.N_CH(N_CH), .W(W), .DEAD_CYC(0)) dut_z (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmd),
        .fwd      (fwd_z),
        .rev      (rev_z),
        .dead     (dead_z),
        .pwm_sync (pwm_sync_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch0(input int v);
        cmd[W:0] = (W+1)'(v);
    endtask

    // Advance to the next cnt == 0 cycle; always moves at least one clock.
    task automatic sync(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!pwm_sync && n < 4096);
        check("sync_seen", 32'(pwm_sync), 1);
    endtask

    task automatic measure(input int ncyc);
        cf0 = 0; cr0 = 0; cf1 = 0; cr1 = 0; cd = 0; cs = 0;
        repeat (ncyc) begin
            step();
            cf0 += int'(fwd[0]);
            cr0 += int'(rev[0]);
            cf1 += int'(fwd[1]);
            cr1 += int'(rev[1]);
            cd  += int'(dead[0]) + int'(dead[1]);
            cs  += int'(pwm_sync);
        end
    endtask

    initial begin
        int         n;
        int         first_dead, first_rev, first_rev_z;
        int         ndead, nfwd, nrev, nrev_z, ndead_z, overlap;
        int         ph1, ph2;
        logic [1:0] prev, cur;

        // ---- reset state, idle brake, pwm_sync period ----
        set_ch0(0);
        step();
        step();
        check("rst_fwd", 32'(fwd), 3);
        check("rst_rev", 32'(rev), 3);
        check("rst_dead", 32'(dead), 0);
        check("rst_sync", 32'(pwm_sync), 0);
        check("rst_fwd_z", 32'(fwd_z & rev_z), 3);
        rst_n = 1'b1;
        sync(n);
        check("first_sync_gap", n, 1024);
        measure(1024);
        check("idle_fwd0", cf0, 1024);
        check("idle_rev0", cr0, 1024);
        check("idle_fwd1", cf1, 1024);
        check("idle_rev1", cr1, 1024);
        check("idle_dead", cd, 0);
        check("idle_sync_cnt", cs, 1);
        check("idle_sync_end", 32'(pwm_sync), 1);

        // ---- +256 forward ----
        set_ch0(256);
        sync(n);
        check("sync_gap", n, 1024);
        check("lat_still_brake", 32'({fwd[0], rev[0]}), 3);
        measure(1024);
        check("f256_fwd0", cf0, 256);
        check("f256_rev0", cr0, 0);
        check("f256_ch1_fwd", cf1, 1024);
        check("f256_ch1_rev", cr1, 1024);
        check("f256_dead", cd, 0);

        // ---- saturation of -1024, then -1 ----
        set_ch0(0);
        sync(n);
        set_ch0(-1024);
        sync(n);
        measure(1024);
        check("sat_rev0", cr0, 1023);
        check("sat_fwd0", cf0, 0);
        check("sat_dead", cd, 0);
        set_ch0(-1);
        sync(n);
        measure(1024);
        check("m1_rev0", cr0, 1);
        check("m1_fwd0", cf0, 0);
        check("m1_ch1", cf1 + cr1, 2048);

        // ---- +512 then -512: dead-time on reversal ----
        set_ch0(0);
        sync(n);
        set_ch0(512);
        sync(n);
        set_ch0(-512);
        first_dead = -1; first_rev = -1; first_rev_z = -1;
        ndead = 0; nfwd = 0; nrev = 0; nrev_z = 0; ndead_z = 0; overlap = 0;
        prev = {fwd[0], rev[0]};
        for (int i = 1; i <= 1040; i++) begin
            step();
            cur = {fwd[0], rev[0]};
            if ((prev == 2'b10 && cur == 2'b01) || (prev == 2'b01 && cur == 2'b10))
                overlap++;
            prev = cur;
            nfwd    += int'(fwd[0]);
            nrev    += int'(rev[0]);
            nrev_z  += int'(rev_z[0]);
            ndead_z += int'(dead_z[0]);
            if (dead[0]) begin
                ndead++;
                if (first_dead < 0) first_dead = i;
            end
            if (rev[0] && first_rev < 0) first_rev = i;
            if (rev_z[0] && first_rev_z < 0) first_rev_z = i;
        end
        check("rv_fwd_cnt", nfwd, 512);
        check("rv_dead_cnt", ndead, 8);
        check("rv_first_dead", first_dead, 1025);
        check("rv_first_rev", first_rev, 1033);
        check("rv_rev_cnt", nrev, 8);
        check("rv_overlap", overlap, 0);
        check("rv_ch1_dead", 32'(dead[1]), 0);
        check("dz_first_rev", first_rev_z, 1025);
        check("dz_rev_cnt", nrev_z, 16);
        check("dz_dead_cnt", ndead_z, 0);

        // ---- mid-period command change ignored until boundary ----
        set_ch0(0);
        sync(n);
        set_ch0(100);
        sync(n);
        ph1 = 0; ph2 = 0;
        for (int i = 1; i <= 2048; i++) begin
            step();
            if (i <= 1024) ph1 += int'(fwd[0]);
            else           ph2 += int'(fwd[0]);
            if (i == 300) set_ch0(900);
        end
        check("mid_period_old", ph1, 100);
        check("mid_period_new", ph2, 900);

        // ---- reset during DEAD ----
        set_ch0(-512);
        sync(n);
        step();
        step();
        step();
        check("in_dead", 32'(dead[0]), 1);
        check("in_dead_pins", 32'({fwd[0], rev[0]}), 0);
        check("dz_direct_rev", 32'({fwd_z[0], rev_z[0], dead_z[0]}), 3'b010);
        rst_n = 1'b0;
        step();
        check("rst_dead_fwd", 32'(fwd), 3);
        check("rst_dead_rev", 32'(rev), 3);
        check("rst_dead_dead", 32'(dead), 0);
        check("rst_dead_sync", 32'(pwm_sync), 0);
        rst_n = 1'b1;
        sync(n);
        check("post_rst_gap", n, 1024);
        check("post_rst_brake", 32'({fwd[0], rev[0]}), 3);
        measure(1024);
        check("post_rst_rev0", cr0, 512);
        check("post_rst_fwd0", cf0, 0);
        check("post_rst_dead", cd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
